// File: rtl/cluster_op2_div_pkg.sv
// cluster_op2_div_pkg: shared widths, constants and FSM states for the clusterOp2 divider
package cluster_op2_div_pkg;
  localparam int DIVIDEND_W = 17;
  localparam int DIVISOR_W = 9;
  localparam logic [DIVIDEND_W-1:0] DBZ_POS_Q = 17'h0FFFF;
  localparam logic [DIVIDEND_W-1:0] DBZ_NEG_Q = 17'h10000;
  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
endpackage

// File: rtl/cluster_op2_sdiv_step.sv
// cluster_op2_sdiv_step: one combinational restoring-division iteration
// Ports: r (partial remainder), bit_in (next dividend magnitude bit), dvs (divisor),
//        r_nxt (next partial remainder), q_bit (quotient bit produced)
module cluster_op2_sdiv_step
  import cluster_op2_div_pkg::*;
(
  input  logic [DIVISOR_W:0]   r,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] dvs,
  output logic [DIVISOR_W:0]   r_nxt,
  output logic                 q_bit
);
  localparam int RW = DIVISOR_W + 1;
  logic [DIVISOR_W+1:0] sh;
  always_comb begin
    sh = {r, bit_in};
    q_bit = sh >= {2'b00, dvs};
    r_nxt = q_bit ? RW'(sh - {2'b00, dvs}) : sh[DIVISOR_W:0];
  end
endmodule

// File: rtl/cluster_op2_sdiv_17s_9ns_seq.sv
// cluster_op2_sdiv_17s_9ns_seq: iterative radix-2 17s / 9ns divider with quotient and remainder
// Ports: clk, reset (sync, active-high), ce (clock enable), in_valid/in_ready + din0/din1 operands,
//        out_valid/out_ready + quot/rem/div_by_zero results.
// Optional: CLUSTEROP2_SDIV_EARLY_EXIT_EN skips CALC when |din0| < din1.
module cluster_op2_sdiv_17s_9ns_seq
  import cluster_op2_div_pkg::*;
#(
  parameter int ITER = DIVIDEND_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] din0,
  input  logic [DIVISOR_W-1:0]  din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quot,
  output logic [DIVISOR_W:0]    rem,
  output logic                  div_by_zero
);
  localparam int CNT_W = $clog2(ITER);
  div_state_t state_q, state_d;
  logic sign_q, sign_d, dbz_q, dbz_d, q_bit;
  logic [DIVIDEND_W-1:0] mag_q, mag_d, quot_q, quot_d, abs0;
  logic [DIVISOR_W-1:0] dvs_q, dvs_d;
  logic [DIVISOR_W:0] r_q, r_d, rem_q, rem_d, r_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  cluster_op2_sdiv_step u_step (
    .r(r_q), .bit_in(mag_q[DIVIDEND_W-1]), .dvs(dvs_q), .r_nxt(r_nxt), .q_bit(q_bit)
  );

  // mag_q shifts left each iteration: the dividend magnitude leaves at the top
  // while quotient bits enter at the bottom, so it holds |quot| after ITER steps.
  always_comb begin
    state_d = state_q;
    sign_d = sign_q;
    mag_d = mag_q;
    dvs_d = dvs_q;
    r_d = r_q;
    cnt_d = cnt_q;
    quot_d = quot_q;
    rem_d = rem_q;
    dbz_d = dbz_q;
    abs0 = din0[DIVIDEND_W-1] ? -din0 : din0;
    if (ce)
      case (state_q)
        IDLE: if (in_valid) begin
          sign_d = din0[DIVIDEND_W-1];
          mag_d = abs0;
          dvs_d = din1;
          r_d = '0;
          cnt_d = '0;
          dbz_d = 1'b0;
          if (din1 == '0) begin
            quot_d = din0[DIVIDEND_W-1] ? DBZ_NEG_Q : DBZ_POS_Q;
            rem_d = din0[DIVISOR_W:0];
            dbz_d = 1'b1;
            state_d = DONE;
          end
`ifdef CLUSTEROP2_SDIV_EARLY_EXIT_EN
          else if (abs0 < {{(DIVIDEND_W-DIVISOR_W){1'b0}}, din1}) begin
            quot_d = '0;
            rem_d = din0[DIVISOR_W:0];
            state_d = DONE;
          end
`endif
          else state_d = CALC;
        end
        CALC: begin
          mag_d = {mag_q[DIVIDEND_W-2:0], q_bit};
          r_d = r_nxt;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITER - 1)) begin
            quot_d = sign_q ? -mag_d : mag_d;
            rem_d = sign_q ? -r_nxt : r_nxt;
            state_d = DONE;
          end
        end
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sign_q <= 1'b0;
      mag_q <= '0;
      dvs_q <= '0;
      r_q <= '0;
      cnt_q <= '0;
      quot_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q <= sign_d;
      mag_q <= mag_d;
      dvs_q <= dvs_d;
      r_q <= r_d;
      cnt_q <= cnt_d;
      quot_q <= quot_d;
      rem_q <= rem_d;
      dbz_q <= dbz_d;
    end
  end

  assign in_ready = ce & (state_q == IDLE);
  assign out_valid = ce & (state_q == DONE);
  assign quot = quot_q;
  assign rem = rem_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_cluster_op2_sdiv_17s_9ns_seq.sv
// tb_cluster_op2_sdiv_17s_9ns_seq: randomized and directed checks of the sequential divider
module tb_cluster_op2_sdiv_17s_9ns_seq;
  logic clk = 0, reset = 1, ce = 1, in_valid = 0, out_ready = 1;
  logic [16:0] din0 = '0;
  logic [8:0] din1 = '0;
  logic in_ready, out_valid, div_by_zero;
  logic [16:0] quot;
  logic [9:0] rem;
  int cmp = 0, bad = 0, cyc = 0, t0 = 0;

  cluster_op2_sdiv_17s_9ns_seq dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .out_valid(out_valid), .out_ready(out_ready),
    .quot(quot), .rem(rem), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // C-style truncating division; divide-by-zero saturates toward the dividend's sign
  function automatic void model(input logic [16:0] a, input logic [8:0] b,
                                output logic [16:0] q, output logic [9:0] r, output logic z);
    int sa, sb, qi, ri;
    sa = $signed(a);
    sb = int'(b);
    if (sb == 0) begin
      qi = sa < 0 ? -65536 : 65535;
      ri = sa;
      z = 1'b1;
    end else begin
      qi = sa / sb;
      ri = sa % sb;
      z = 1'b0;
    end
    q = qi[16:0];
    r = ri[9:0];
  endfunction

  function automatic int lat_of(input logic [16:0] a, input logic [8:0] b);
    int sa;
    sa = $signed(a);
    if (sa < 0) sa = -sa;
    if (b == 0) return 1;
`ifdef CLUSTEROP2_SDIV_EARLY_EXIT_EN
    if (sa < int'(b)) return 1;
`endif
    return 18;
  endfunction

  // Monitor: tracks the one operation in flight, counts ce-high cycles to completion
  // and checks every output on every cycle against the model.
  logic [16:0] eq;
  logic [9:0] er;
  logic ed, busy = 0, seen = 0, acc;
  int elat = 0, k = 0;
  always @(negedge clk) begin
    if (reset) begin
      busy = 0;
      seen = 0;
    end else begin
      acc = ce && in_valid && !busy;
      chk("in_ready", in_ready, ce && !busy);
      if (busy && !seen && ce) begin
        k++;
        if (out_valid || k == elat) begin
          chk("latency", k, elat);
          seen = 1;
        end
      end
      chk("out_valid", out_valid, ce && busy && seen);
      if (busy && seen && out_valid) begin
        chk("quot", quot, eq);
        chk("rem", rem, er);
        chk("div_by_zero", div_by_zero, ed);
        if (out_ready) begin
          busy = 0;
          seen = 0;
        end
      end
      if (acc) begin
        busy = 1;
        seen = 0;
        k = 0;
        model(din0, din1, eq, er, ed);
        elat = lat_of(din0, din1);
      end
    end
  end

  task automatic start(input logic [16:0] a, input logic [8:0] b, input int bp);
    int w;
    din0 = a;
    din1 = b;
    out_ready = (bp == 0);
    in_valid = 1;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w == 100) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 0;
    t0 = cyc;
  endtask

  task automatic op(input logic [16:0] a, input logic [8:0] b, input int bp, input int gap);
    int w;
    start(a, b, bp);
    if (gap > 0) begin
      repeat (6) @(posedge clk);
      #1 ce = 0;
      repeat (gap) @(posedge clk);
      #1 ce = 1;
    end
    w = 0;
    while (!out_valid && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("wall_latency", cyc - t0 + 1, lat_of(a, b) + gap);
    if (bp > 0) begin
      repeat (bp) @(posedge clk);
      #1 out_ready = 1;
    end
    @(posedge clk);
    #1 out_ready = 1;
  endtask

  logic [16:0] pq, ra;
  logic [9:0] pr;
  logic [8:0] rb;
  logic pz;
  initial begin
    model(17'd100, 9'd7, pq, pr, pz);
    chk("model_100_7_q", pq, 17'd14);
    chk("model_100_7_r", pr, 10'd2);
    model(17'h1FF9C, 9'd7, pq, pr, pz);
    chk("model_m100_7_q", pq, 17'h1FFF2);
    chk("model_m100_7_r", pr, 10'h3FE);
    model(17'h10000, 9'd1, pq, pr, pz);
    chk("model_m65536_1_q", pq, 17'h10000);
    model(17'd5, 9'd0, pq, pr, pz);
    chk("model_5_0", {pz, pr, pq}, {1'b1, 10'd5, 17'h0FFFF});
    model(17'h1FFFB, 9'd0, pq, pr, pz);
    chk("model_m5_0_q", pq, 17'h10000);

    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("reset_quot", quot, 0);
    chk("reset_rem", rem, 0);
    chk("reset_dbz", div_by_zero, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    @(posedge clk);
    #1;

    op(17'd100, 9'd7, 0, 0);
    op(17'h1FF9C, 9'd7, 0, 0);
    op(17'h10000, 9'd1, 0, 0);
    op(17'd5, 9'd0, 0, 0);
    op(17'h1FFFB, 9'd0, 0, 0);
    op(17'd3, 9'd200, 0, 0);
    op(17'h0FFFF, 9'd1, 0, 0);
    op(17'h0FFFF, 9'd511, 0, 0);
    op(17'h10000, 9'd511, 0, 0);
    op(17'h1FFFF, 9'd511, 0, 0);
    op(17'd1000, 9'd3, 10, 0);
    op(17'd12345, 9'd17, 0, 5);

    start(17'd40000, 9'd13, 0);
    repeat (8) @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    op(17'd255, 9'd255, 0, 0);

    for (int i = 0; i < 1500; i++) begin
      ra = 17'($urandom);
      case ($urandom_range(0, 7))
        0: rb = 9'd0;
        1, 2: rb = 9'($urandom_range(1, 16));
        3: rb = 9'd511;
        default: rb = 9'($urandom);
      endcase
      if ($urandom_range(0, 9) == 0) ra = ($urandom_range(0, 1) == 1) ? 17'h10000 : 17'h0FFFF;
      op(ra, rb, $urandom_range(0, 2), 0);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
